// File: rtl/dcache_mem_bridge_if.sv
// Dcache-side request/response and single-ID read/write bus bundle for dcache_mem_bridge.
// The master modport is the bridge's view; slave is the Dcache and memory environment.
interface dcache_mem_bridge_if #(
    parameter int unsigned offset_width = 2
);
    localparam int unsigned LW = 32 * (1 << offset_width);

    logic          dcache_mem_req;
    logic          dcache_mem_wr;
    logic          dcache_mem_SUC;
    logic [31:0]   addr_dcache_mem;
    logic [31:0]   dout_dcache_mem;
    logic [1:0]    dcache_mem_size;
    logic [3:0]    dcache_mem_wstrb;
    logic          mem_dcache_addrOK;
    logic          mem_dcache_dataOK;
    logic [LW-1:0] din_mem_dcache;

    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    logic [31:0]   awaddr;
    logic [2:0]    awsize;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic          bvalid;
    logic          bready;

    modport master (
        input  dcache_mem_req, dcache_mem_wr, dcache_mem_SUC, addr_dcache_mem,
               dout_dcache_mem, dcache_mem_size, dcache_mem_wstrb,
        output mem_dcache_addrOK, mem_dcache_dataOK, din_mem_dcache,
        output araddr, arlen, arsize, arvalid, rready,
        input  arready, rdata, rlast, rvalid,
        output awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bvalid
    );

    modport slave (
        output dcache_mem_req, dcache_mem_wr, dcache_mem_SUC, addr_dcache_mem,
               dout_dcache_mem, dcache_mem_size, dcache_mem_wstrb,
        input  mem_dcache_addrOK, mem_dcache_dataOK, din_mem_dcache,
        input  araddr, arlen, arsize, arvalid, rready,
        output arready, rdata, rlast, rvalid,
        input  awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bvalid
    );
endinterface

// File: rtl/dcache_mem_bridge.sv
// Bridges Dcache line refills, uncached reads and single-beat writes onto a burst read /
// single-beat write bus, one transaction outstanding at a time.
module dcache_mem_bridge #(
    parameter int unsigned offset_width = 2
) (
    input  logic               clk,
    input  logic               rst,
    dcache_mem_bridge_if.master bus
);
    localparam int unsigned NW = 1 << offset_width;

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} state_e;

    state_e                   state_q, state_d;
    logic [offset_width-1:0]  beat_cnt_q, beat_cnt_d;
    logic [NW-1:0][31:0]      line_q, line_d;
    logic [31:0]              araddr_q, araddr_d;
    logic [7:0]               arlen_q, arlen_d;
    logic [2:0]               arsize_q, arsize_d;
    logic [31:0]              awaddr_q, awaddr_d;
    logic [2:0]               awsize_q, awsize_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [3:0]               wstrb_q, wstrb_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     wlast_q, wlast_d;
    logic                     bready_q, bready_d;
    logic                     dataok_q, dataok_d;
    logic                     aw_done, w_done;

    // Each write channel is finished once its valid has dropped or handshakes this cycle.
    assign aw_done = !awvalid_q || bus.awready;
    assign w_done  = !wvalid_q  || bus.wready;

    // Next-state and output-register logic.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        awaddr_d   = awaddr_q;
        awsize_d   = awsize_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        wlast_d    = wlast_q;
        bready_d   = bready_q;
        dataok_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.dcache_mem_req) begin
                    if (bus.dcache_mem_wr) begin
                        awaddr_d  = bus.addr_dcache_mem;
                        awsize_d  = {1'b0, bus.dcache_mem_size};
                        wdata_d   = bus.dout_dcache_mem;
                        wstrb_d   = bus.dcache_mem_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        wlast_d   = 1'b1;
                        state_d   = AW_W;
                    end else begin
                        araddr_d  = bus.addr_dcache_mem;
                        arlen_d   = bus.dcache_mem_SUC ? 8'd0 : 8'(NW - 1);
                        arsize_d  = bus.dcache_mem_SUC ? {1'b0, bus.dcache_mem_size} : 3'd2;
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end
                end
            end
            AR: begin
                if (bus.arready) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = R;
                end
            end
            R: begin
                if (bus.rvalid) begin
                    line_d[beat_cnt_q] = bus.rdata;
                    // Saturate so over-long bursts keep landing in the last word.
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + offset_width'(1);
                    end
                    if (bus.rlast) begin
                        rready_d   = 1'b0;
                        beat_cnt_d = '0;
                        dataok_d   = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            AW_W: begin
                if (awvalid_q && bus.awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && bus.wready) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = B;
                end
            end
            B: begin
                if (bus.bvalid) begin
                    bready_d = 1'b0;
                    dataok_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            line_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            awaddr_q   <= '0;
            awsize_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
            dataok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            awaddr_q   <= awaddr_d;
            awsize_q   <= awsize_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            wlast_q    <= wlast_d;
            bready_q   <= bready_d;
            dataok_q   <= dataok_d;
        end
    end

    // Acceptance is immediate in IDLE, so addrOK is the only combinational output.
    assign bus.mem_dcache_addrOK = (state_q == IDLE) && bus.dcache_mem_req;
    assign bus.mem_dcache_dataOK = dataok_q;
    assign bus.din_mem_dcache    = line_q;
    assign bus.araddr            = araddr_q;
    assign bus.arlen             = arlen_q;
    assign bus.arsize            = arsize_q;
    assign bus.arvalid           = arvalid_q;
    assign bus.rready            = rready_q;
    assign bus.awaddr            = awaddr_q;
    assign bus.awsize            = awsize_q;
    assign bus.awvalid           = awvalid_q;
    assign bus.wdata             = wdata_q;
    assign bus.wstrb             = wstrb_q;
    assign bus.wlast             = wlast_q;
    assign bus.wvalid            = wvalid_q;
    assign bus.bready            = bready_q;
endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Randomized bench for dcache_mem_bridge: drives Dcache and bus sides cycle by cycle and
// compares against a transaction-level model of the expected bus fields and cache line.
module tb_dcache_mem_bridge;
    localparam int unsigned OW = 2;
    localparam int unsigned NW = 1 << OW;
    localparam int unsigned LW = 32 * NW;

    logic clk = 1'b0;
    logic rst;

    int                  n_checks;
    int                  n_errors;
    bit                  pend;
    logic [NW-1:0][31:0] exp_words;

    bit          r_wr, r_suc, r_hold;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    int          r_nb;

    dcache_mem_bridge_if #(.offset_width(OW)) bus_if ();

    dcache_mem_bridge #(.offset_width(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.arready = 1'b0;
        bus_if.rvalid  = 1'b0;
        bus_if.rlast   = 1'b0;
        bus_if.rdata   = $urandom;
        bus_if.awready = 1'b0;
        bus_if.wready  = 1'b0;
        bus_if.bvalid  = 1'b0;
    endtask

    // Request line with arbitrary attributes; anything presented while busy must be ignored.
    task automatic dc_noise(input bit req);
        bus_if.dcache_mem_req   = req;
        bus_if.dcache_mem_wr    = 1'($urandom);
        bus_if.dcache_mem_SUC   = 1'($urandom);
        bus_if.addr_dcache_mem  = $urandom;
        bus_if.dout_dcache_mem  = $urandom;
        bus_if.dcache_mem_size  = 2'($urandom);
        bus_if.dcache_mem_wstrb = 4'($urandom);
    endtask

    function automatic logic [4:0] handshake_outs();
        return {bus_if.arvalid, bus_if.awvalid, bus_if.wvalid, bus_if.rready, bus_if.bready};
    endfunction

    task automatic idle_cycle();
        bus_idle();
        dc_noise(1'b0);
        #1;
        check("data_ok", bus_if.mem_dcache_dataOK, pend);
        check("din_hold", bus_if.din_mem_dcache, exp_words);
        check("addr_ok_idle", bus_if.mem_dcache_addrOK, 0);
        check("quiet_idle", handshake_outs(), 0);
        pend = 1'b0;
        cyc();
    endtask

    // One full transaction; d_a = AR or AW delay, d_w = W delay, d_b = B delay.
    task automatic run_txn(input bit wr, input bit suc, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [3:0] strb, input int d_a, input int d_w,
                           input int d_b, input int nbeats, input logic [31:0] rbase,
                           input int rst_at, input bit hold);
        int last;
        int gap;
        int idx;
        bus_idle();
        bus_if.dcache_mem_req   = 1'b1;
        bus_if.dcache_mem_wr    = wr;
        bus_if.dcache_mem_SUC   = suc;
        bus_if.addr_dcache_mem  = addr;
        bus_if.dout_dcache_mem  = wdat;
        bus_if.dcache_mem_size  = size;
        bus_if.dcache_mem_wstrb = strb;
        #1;
        check("data_ok_prev", bus_if.mem_dcache_dataOK, pend);
        check("din_prev", bus_if.din_mem_dcache, exp_words);
        check("addr_ok", bus_if.mem_dcache_addrOK, 1);
        check("quiet_accept", handshake_outs(), 0);
        pend = 1'b0;
        cyc();
        if (!wr) begin
            for (int k = 0; k <= d_a; k++) begin
                bus_idle();
                dc_noise(hold);
                bus_if.arready = (k == d_a);
                #1;
                check("ar_valid", bus_if.arvalid, 1);
                check("ar_addr", bus_if.araddr, addr);
                check("ar_len", bus_if.arlen, suc ? 0 : NW - 1);
                check("ar_size", bus_if.arsize, suc ? {1'b0, size} : 3'd2);
                check("addr_ok_busy", bus_if.mem_dcache_addrOK, 0);
                check("data_ok_busy", bus_if.mem_dcache_dataOK, 0);
                check("r_ready_ar", bus_if.rready, 0);
                cyc();
            end
            for (int b = 0; b < nbeats; b++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    bus_idle();
                    dc_noise(hold);
                    #1;
                    check("r_ready_gap", bus_if.rready, 1);
                    check("addr_ok_busy", bus_if.mem_dcache_addrOK, 0);
                    check("data_ok_busy", bus_if.mem_dcache_dataOK, 0);
                    cyc();
                end
                bus_idle();
                dc_noise(hold);
                if (b == rst_at) begin
                    rst = 1'b1;
                    #1;
                    cyc();
                    rst = 1'b0;
                    bus_idle();
                    dc_noise(1'b0);
                    #1;
                    check("rst_quiet", handshake_outs(), 0);
                    check("rst_data_ok", bus_if.mem_dcache_dataOK, 0);
                    check("rst_din", bus_if.din_mem_dcache, 0);
                    exp_words = '0;
                    pend      = 1'b0;
                    cyc();
                    return;
                end
                bus_if.rvalid = 1'b1;
                bus_if.rlast  = (b == nbeats - 1);
                bus_if.rdata  = (rbase != 0) ? rbase + 32'(b) : $urandom;
                idx = (b < int'(NW)) ? b : int'(NW) - 1;
                exp_words[idx[OW-1:0]] = bus_if.rdata;
                #1;
                check("r_ready", bus_if.rready, 1);
                check("ar_valid_r", bus_if.arvalid, 0);
                check("addr_ok_busy", bus_if.mem_dcache_addrOK, 0);
                check("data_ok_busy", bus_if.mem_dcache_dataOK, 0);
                cyc();
            end
            pend = 1'b1;
        end else begin
            last = (d_a > d_w) ? d_a : d_w;
            for (int k = 0; k <= last; k++) begin
                bus_idle();
                dc_noise(hold);
                bus_if.awready = (k == d_a);
                bus_if.wready  = (k == d_w);
                #1;
                check("aw_valid", bus_if.awvalid, k <= d_a);
                check("w_valid", bus_if.wvalid, k <= d_w);
                if (k <= d_a) begin
                    check("aw_addr", bus_if.awaddr, addr);
                    check("aw_size", bus_if.awsize, {1'b0, size});
                end
                if (k <= d_w) begin
                    check("w_data", bus_if.wdata, wdat);
                    check("w_strb", bus_if.wstrb, strb);
                    check("w_last", bus_if.wlast, 1);
                end
                check("b_ready_aw", bus_if.bready, 0);
                check("addr_ok_busy", bus_if.mem_dcache_addrOK, 0);
                check("data_ok_busy", bus_if.mem_dcache_dataOK, 0);
                cyc();
            end
            for (int k = 0; k <= d_b; k++) begin
                bus_idle();
                dc_noise(hold);
                bus_if.bvalid = (k == d_b);
                #1;
                check("b_ready", bus_if.bready, 1);
                check("aw_w_low_b", {bus_if.awvalid, bus_if.wvalid}, 0);
                check("addr_ok_busy", bus_if.mem_dcache_addrOK, 0);
                check("data_ok_busy", bus_if.mem_dcache_dataOK, 0);
                cyc();
            end
            pend = 1'b1;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        pend      = 1'b0;
        exp_words = '0;
        rst       = 1'b1;
        bus_idle();
        dc_noise(1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_quiet", handshake_outs(), 0);
        check("reset_data_ok", bus_if.mem_dcache_dataOK, 0);
        check("reset_din", bus_if.din_mem_dcache, 0);
        check("reset_araddr", bus_if.araddr, 0);
        check("reset_awaddr", bus_if.awaddr, 0);
        check("reset_wdata", bus_if.wdata, 0);
        cyc();

        // Cached line refill with immediate arready.
        run_txn(0, 0, 2'd2, 32'h1000_0040, 32'h0, 4'h0, 0, 0, 0, NW, 32'hA0, -1, 0);
        idle_cycle();
        check("line_cached", bus_if.din_mem_dcache,
              {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Uncached byte read at an unaligned address lands in word 0.
        run_txn(0, 1, 2'd0, 32'h1FE0_01E5, 32'h0, 4'h0, 1, 0, 0, 1, 32'h55, -1, 0);
        idle_cycle();
        check("line_uncached", bus_if.din_mem_dcache,
              {32'hA3, 32'hA2, 32'hA1, 32'h55});

        // Write with wready three cycles after awready, then same-cycle handshakes.
        run_txn(1, 0, 2'd2, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 0, 3, 1, 0, 0, -1, 0);
        idle_cycle();
        run_txn(1, 0, 2'd1, 32'h0000_0202, 32'h1234_5678, 4'b1100, 0, 0, 1, 0, 0, -1, 0);
        idle_cycle();

        // Reset after two beats abandons the refill; the next refill starts at word 0.
        run_txn(0, 0, 2'd2, 32'h2000_0080, 32'h0, 4'h0, 0, 0, 0, NW, 32'hB0, 2, 0);
        idle_cycle();
        run_txn(0, 0, 2'd2, 32'h3000_00C0, 32'h0, 4'h0, 1, 0, 0, NW, 32'hC0, -1, 0);
        idle_cycle();
        check("line_after_rst", bus_if.din_mem_dcache,
              {32'hC3, 32'hC2, 32'hC1, 32'hC0});

        // Request held high while busy, next request accepted in the dataOK cycle.
        run_txn(0, 0, 2'd2, 32'h4000_0100, 32'h0, 4'h0, 2, 0, 0, NW, 32'h0, -1, 1);
        run_txn(1, 1, 2'd0, 32'h4000_0103, 32'h0000_00EE, 4'b1000, 1, 0, 0, 0, 0, -1, 1);
        idle_cycle();

        // Over-long burst keeps overwriting the last word.
        run_txn(0, 0, 2'd2, 32'h5000_0010, 32'h0, 4'h0, 0, 0, 0, NW + 2, 32'hE0, -1, 0);
        idle_cycle();
        check("line_overflow", bus_if.din_mem_dcache,
              {32'hE5, 32'hE2, 32'hE1, 32'hE0});

        for (int t = 0; t < 40; t++) begin
            r_wr   = 1'($urandom);
            r_suc  = 1'($urandom);
            r_hold = 1'($urandom);
            r_size = r_suc ? 2'($urandom_range(0, 2)) : 2'd2;
            r_addr = $urandom;
            if (!r_wr && !r_suc) begin
                r_addr[OW+1:0] = '0;
            end
            r_nb = r_suc ? 1 : int'(NW) + (($urandom_range(0, 4) == 0) ? 1 : 0);
            run_txn(r_wr, r_suc, r_size, r_addr, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    r_nb, 32'h0, -1, r_hold);
            if ($urandom_range(0, 1) == 1) begin
                idle_cycle();
            end
        end
        idle_cycle();
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
